uart_tx_sched: RTL and testbench

- Round-robin scheduler that shares the single UART serial transmitter between two byte requesters.
- Accepts one byte at a time over a valid/ready handshake and launches it with a one-cycle tx_en pulse.
- Tracks frame completion from the transmitter's busy flag, then enforces an inter-frame idle gap.
- Sits between the APB register/FIFO logic and the transmitter.

---
 rtl/uart_tx_sched.sv | 153 +++++++++++++++
 tb/tb_uart_tx_sched.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one UART transmitter
// between two byte requesters.
//
// Ports:
//   clk, arst_n, rst     clock, async active-low reset, sync active-high clear
//   enable               gates new accepts (sampled in IDLE only)
//   req0_valid/data      requester 0 byte offer; req0_ready = accepted this cycle
//   req1_valid/data      requester 1 byte offer; req1_ready = accepted this cycle
//   tx_en, tx_data       one-cycle launch pulse and byte held until next accept
//   tx_busy              transmitter busy flag
//   sched_busy           high whenever the scheduler is not IDLE
//   last_src             source of the most recently accepted byte
//   frame_cnt            completed-frame counter (wraps)
//   timeout_err          sticky flag: tx_busy never rose after a launch
module uart_tx_sched #(
    parameter int unsigned GAP_CYCLES    = 16,
    parameter int unsigned START_TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        rst,
    input  logic        enable,
    input  logic        req0_valid,
    input  logic [7:0]  req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_data,
    output logic        req1_ready,
    output logic        tx_en,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    output logic        sched_busy,
    output logic        last_src,
    output logic [15:0] frame_cnt,
    output logic        timeout_err
);

    localparam int unsigned TW = $clog2(START_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_START,
        S_WAIT_END,
        S_GAP
    } state_t;

    state_t        state_q;
    logic          prio_q;
    logic          tx_en_q;
    logic [7:0]    tx_data_q;
    logic          last_src_q;
    logic [15:0]   frame_cnt_q;
    logic          timeout_err_q;
    logic [15:0]   gap_cnt_q;
    logic [TW-1:0] to_cnt_q;

    logic grant;
    logic accept;

    // A lone valid requester wins outright; with both (or neither) valid
    // the rotating priority decides.
    always_comb begin
        grant = prio_q;
        if (req0_valid && !req1_valid) begin
            grant = 1'b0;
        end else if (!req0_valid && req1_valid) begin
            grant = 1'b1;
        end
    end

    assign accept     = (state_q == S_IDLE) && enable && (req0_valid || req1_valid);
    assign req0_ready = accept && req0_valid && !grant;
    assign req1_ready = accept && req1_valid && grant;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q       <= S_IDLE;
            prio_q        <= 1'b0;
            tx_en_q       <= 1'b0;
            tx_data_q     <= '0;
            last_src_q    <= 1'b0;
            frame_cnt_q   <= '0;
            timeout_err_q <= 1'b0;
            gap_cnt_q     <= '0;
            to_cnt_q      <= '0;
        end else if (rst) begin
            state_q       <= S_IDLE;
            prio_q        <= 1'b0;
            tx_en_q       <= 1'b0;
            tx_data_q     <= '0;
            last_src_q    <= 1'b0;
            frame_cnt_q   <= '0;
            timeout_err_q <= 1'b0;
            gap_cnt_q     <= '0;
            to_cnt_q      <= '0;
        end else begin
            tx_en_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        tx_data_q  <= grant ? req1_data : req0_data;
                        last_src_q <= grant;
                        prio_q     <= !grant;
                        // Registered pulse: high exactly while in LAUNCH.
                        tx_en_q    <= 1'b1;
                        state_q    <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    to_cnt_q <= TW'(START_TIMEOUT);
                    state_q  <= S_WAIT_START;
                end
                S_WAIT_START: begin
                    if (tx_busy) begin
                        state_q <= S_WAIT_END;
                    end else if (to_cnt_q == TW'(1)) begin
                        timeout_err_q <= 1'b1;
                        state_q       <= S_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q - TW'(1);
                    end
                end
                S_WAIT_END: begin
                    if (!tx_busy) begin
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                        if (GAP_CYCLES == 0) begin
                            state_q <= S_IDLE;
                        end else begin
                            gap_cnt_q <= 16'(GAP_CYCLES);
                            state_q   <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    gap_cnt_q <= gap_cnt_q - 16'd1;
                    if (gap_cnt_q == 16'd1) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx_en       = tx_en_q;
    assign tx_data     = tx_data_q;
    assign sched_busy  = (state_q != S_IDLE);
    assign last_src    = last_src_q;
    assign frame_cnt   = frame_cnt_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Testbench for uart_tx_sched: one instance with a 16-cycle gap, one with
// no gap. Each instance gets its own transmitter model that raises busy the
// cycle after tx_en and holds it for blen clocks.
module tb_uart_tx_sched;

    localparam int unsigned T = 4;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        req0_valid = 1'b0;
    logic [7:0]  req0_data = '0;
    logic        req1_valid = 1'b0;
    logic [7:0]  req1_data = '0;
    logic        tx_busy = 1'b0;
    logic        z_busy = 1'b0;

    logic        req0_ready, req1_ready, tx_en, sched_busy, last_src, timeout_err;
    logic [7:0]  tx_data;
    logic [15:0] frame_cnt;
    logic        z_req0_ready, z_req1_ready, z_tx_en, z_sched_busy, z_last_src, z_timeout_err;
    logic [7:0]  z_tx_data;
    logic [15:0] z_frame_cnt;

    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned blen = 20;
    bit          auto_busy = 1'b0;
    bit          mprio[2];
    int unsigned mframes[2];

    uart_tx_sched #(.GAP_CYCLES(16), .START_TIMEOUT(T)) dut (
        .clk(clk), .arst_n(arst_n), .rst(rst), .enable(enable),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .tx_en(tx_en), .tx_data(tx_data), .tx_busy(tx_busy),
        .sched_busy(sched_busy), .last_src(last_src), .frame_cnt(frame_cnt),
        .timeout_err(timeout_err)
    );

    uart_tx_sched #(.GAP_CYCLES(0), .START_TIMEOUT(T)) dut0 (
        .clk(clk), .arst_n(arst_n), .rst(rst), .enable(enable),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(z_req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(z_req1_ready),
        .tx_en(z_tx_en), .tx_data(z_tx_data), .tx_busy(z_busy),
        .sched_busy(z_sched_busy), .last_src(z_last_src), .frame_cnt(z_frame_cnt),
        .timeout_err(z_timeout_err)
    );

    always #5 clk = ~clk;

    // Transmitter models: busy high for blen clocks starting the cycle after tx_en.
    int unsigned brem = 0, zrem = 0;
    bit          bpend = 1'b0, zpend = 1'b0;
    always @(negedge clk) begin
        if (!arst_n || rst || !auto_busy) begin
            tx_busy = 1'b0; brem = 0; bpend = 1'b0;
            z_busy  = 1'b0; zrem = 0; zpend = 1'b0;
        end else begin
            if (brem > 0) begin brem--; if (brem == 0) tx_busy = 1'b0; end
            if (bpend) begin bpend = 1'b0; tx_busy = 1'b1; brem = blen; end
            if (tx_en) bpend = 1'b1;
            if (zrem > 0) begin zrem--; if (zrem == 0) z_busy = 1'b0; end
            if (zpend) begin zpend = 1'b0; z_busy = 1'b1; zrem = blen; end
            if (z_tx_en) zpend = 1'b1;
        end
    end

    task automatic do_rst();
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); @(negedge clk); rst = 1'b0;
        mprio[0] = 1'b0; mprio[1] = 1'b0; mframes[0] = 0; mframes[1] = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++; if ({tx_en, tx_data, last_src, frame_cnt, timeout_err, sched_busy} !== 28'd0) begin
            bad++; $display("FAIL reset_outputs: got %h want 0", {tx_en, tx_data, last_src, frame_cnt, timeout_err, sched_busy});
        end
        arst_n = 1'b1; enable = 1'b1;
        mprio[0] = 1'b0; mprio[1] = 1'b0; mframes[0] = 0; mframes[1] = 0;
        @(negedge clk);
        total++; if ({req0_ready, req1_ready, sched_busy} !== 3'b000) begin
            bad++; $display("FAIL reset_idle: got %b want 000", {req0_ready, req1_ready, sched_busy});
        end
    endtask

    task automatic test_single();
        auto_busy = 1'b1; blen = 20;
        @(negedge clk); req0_valid = 1'b1; req0_data = 8'hA5; #1;
        total++; if ({req0_ready, req1_ready} !== 2'b10) begin
            bad++; $display("FAIL single_ready: got %b want 10", {req0_ready, req1_ready});
        end
        @(negedge clk); req0_valid = 1'b0;
        total++; if ({tx_en, tx_data, last_src} !== {1'b1, 8'hA5, 1'b0}) begin
            bad++; $display("FAIL single_launch: got %h want %h", {tx_en, tx_data, last_src}, {1'b1, 8'hA5, 1'b0});
        end
        mprio[0] = 1'b1;
        @(negedge clk);
        total++; if (tx_en !== 1'b0) begin
            bad++; $display("FAIL single_pulse: got %b want 0", tx_en);
        end
        repeat (blen) @(negedge clk);
        total++; if ({frame_cnt, sched_busy} !== {16'd0, 1'b1}) begin
            bad++; $display("FAIL single_cnt_before: got %h want %h", {frame_cnt, sched_busy}, {16'd0, 1'b1});
        end
        @(negedge clk);
        mframes[0] = 1;
        total++; if (frame_cnt !== 16'd1) begin
            bad++; $display("FAIL single_cnt_after: got %0d want 1", frame_cnt);
        end
        repeat (15) @(negedge clk);
        total++; if (sched_busy !== 1'b1) begin
            bad++; $display("FAIL single_gap_end: got %b want 1", sched_busy);
        end
        @(negedge clk);
        total++; if (sched_busy !== 1'b0) begin
            bad++; $display("FAIL single_gap_idle: got %b want 0", sched_busy);
        end
    endtask

    // Drives queued bytes on both requesters and checks grant order, launch
    // data/source, accept-to-launch latency and launch spacing.
    task automatic run_sched(input bit use_z, input int unsigned n0, input int unsigned n1, input bit fixed);
        logic [7:0] q0[$];
        logic [7:0] q1[$];
        logic [8:0] expq[$];
        logic [8:0] e;
        logic [7:0] b;
        logic       r0, r1, en, ls, sb, s;
        logic [7:0] d;
        int unsigned cyc = 0, last_en = 0, rdy_cyc = 0, launches = 0;
        int unsigned gap = use_z ? 0 : 16;
        bit seen = 1'b0, done = 1'b0;
        for (int i = 0; i < int'(n0); i++) q0.push_back(fixed ? 8'h11 : 8'($urandom));
        for (int i = 0; i < int'(n1); i++) q1.push_back(fixed ? 8'h22 : 8'($urandom));
        while (!done && cyc < 3000) begin
            @(negedge clk); cyc++;
            en = use_z ? z_tx_en : tx_en;
            d  = use_z ? z_tx_data : tx_data;
            ls = use_z ? z_last_src : last_src;
            if (en) begin
                launches++;
                total++;
                if (expq.size() == 0) begin
                    bad++; $display("FAIL sched_spurious_tx_en: got 1 want 0 at cycle %0d", cyc);
                end else begin
                    e = expq.pop_front();
                    if ({ls, d} !== e) begin
                        bad++; $display("FAIL sched_launch: got src=%b data=%h want src=%b data=%h", ls, d, e[8], e[7:0]);
                    end
                end
                total++; if (cyc !== rdy_cyc + 1) begin
                    bad++; $display("FAIL sched_latency: got %0d want %0d", cyc - rdy_cyc, 1);
                end
                if (seen) begin
                    total++; if (cyc - last_en !== blen + gap + 3) begin
                        bad++; $display("FAIL sched_spacing: got %0d want %0d", cyc - last_en, blen + gap + 3);
                    end
                end
                seen = 1'b1; last_en = cyc;
            end
            req0_valid = (q0.size() != 0); req0_data = (q0.size() != 0) ? q0[0] : 8'h00;
            req1_valid = (q1.size() != 0); req1_data = (q1.size() != 0) ? q1[0] : 8'h00;
            #1;
            r0 = use_z ? z_req0_ready : req0_ready;
            r1 = use_z ? z_req1_ready : req1_ready;
            total++; if (r0 && r1) begin
                bad++; $display("FAIL sched_both_ready: got 11 want not both");
            end
            if (r0 || r1) begin
                if (q0.size() != 0 && q1.size() != 0) s = mprio[use_z];
                else s = (q0.size() == 0);
                total++; if (r1 !== s) begin
                    bad++; $display("FAIL sched_grant: got %b want %b", r1, s);
                end
                b = s ? q1[0] : q0[0];
                expq.push_back({s, b});
                if (r1) void'(q1.pop_front()); else void'(q0.pop_front());
                mprio[use_z] = !s;
                mframes[use_z]++;
                rdy_cyc = cyc;
            end
            sb = use_z ? z_sched_busy : sched_busy;
            if (q0.size() == 0 && q1.size() == 0 && expq.size() == 0 && !sb && launches == n0 + n1) done = 1'b1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        total++; if (!done) begin
            bad++; $display("FAIL sched_timeout: got launches=%0d want %0d", launches, n0 + n1);
        end
        total++; if ((use_z ? z_frame_cnt : frame_cnt) !== 16'(mframes[use_z])) begin
            bad++; $display("FAIL sched_frame_cnt: got %0d want %0d", use_z ? z_frame_cnt : frame_cnt, mframes[use_z]);
        end
    endtask

    task automatic test_contention();
        do_rst();
        auto_busy = 1'b1; blen = 20;
        run_sched(1'b0, 2, 2, 1'b1);
        for (int k = 0; k < 3; k++) begin
            blen = $urandom_range(3, 12);
            run_sched(1'b0, $urandom_range(0, 3), $urandom_range(1, 3), 1'b0);
        end
    endtask

    task automatic test_timeout();
        auto_busy = 1'b0;
        @(negedge clk); req1_valid = 1'b1; req1_data = 8'h3C; #1;
        total++; if ({req0_ready, req1_ready} !== 2'b01) begin
            bad++; $display("FAIL to_ready: got %b want 01", {req0_ready, req1_ready});
        end
        @(negedge clk); req1_valid = 1'b0;
        total++; if ({tx_en, tx_data, last_src} !== {1'b1, 8'h3C, 1'b1}) begin
            bad++; $display("FAIL to_launch: got %h want %h", {tx_en, tx_data, last_src}, {1'b1, 8'h3C, 1'b1});
        end
        mprio[0] = 1'b0;
        repeat (T) @(negedge clk);
        total++; if ({timeout_err, sched_busy} !== 2'b01) begin
            bad++; $display("FAIL to_before: got %b want 01", {timeout_err, sched_busy});
        end
        @(negedge clk);
        total++; if ({timeout_err, sched_busy, frame_cnt} !== {2'b10, 16'(mframes[0])}) begin
            bad++; $display("FAIL to_flag: got %h want %h", {timeout_err, sched_busy, frame_cnt}, {2'b10, 16'(mframes[0])});
        end
        req0_valid = 1'b1; req0_data = 8'h5A; #1;
        total++; if (req0_ready !== 1'b1) begin
            bad++; $display("FAIL to_next_ready: got %b want 1", req0_ready);
        end
        @(negedge clk); req0_valid = 1'b0;
        total++; if ({tx_en, tx_data, last_src} !== {1'b1, 8'h5A, 1'b0}) begin
            bad++; $display("FAIL to_next_launch: got %h want %h", {tx_en, tx_data, last_src}, {1'b1, 8'h5A, 1'b0});
        end
        mprio[0] = 1'b1;
        repeat (T + 1) @(negedge clk);
        total++; if ({timeout_err, sched_busy} !== 2'b10) begin
            bad++; $display("FAIL to_sticky: got %b want 10", {timeout_err, sched_busy});
        end
    endtask

    task automatic test_enable();
        int unsigned hits = 0;
        int unsigned lim = 0;
        auto_busy = 1'b1; blen = 20;
        @(negedge clk); enable = 1'b0; req0_valid = 1'b1; req0_data = 8'h66;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1; if (req0_ready || req1_ready) hits++;
        end
        total++; if (hits !== 0) begin
            bad++; $display("FAIL en_gated: got %0d ready cycles want 0", hits);
        end
        enable = 1'b1; #1;
        total++; if (req0_ready !== 1'b1) begin
            bad++; $display("FAIL en_ready: got %b want 1", req0_ready);
        end
        @(negedge clk); req0_data = 8'h77;
        total++; if ({tx_en, tx_data} !== {1'b1, 8'h66}) begin
            bad++; $display("FAIL en_launch: got %h want %h", {tx_en, tx_data}, {1'b1, 8'h66});
        end
        mprio[0] = 1'b1;
        repeat (3) @(negedge clk);
        enable = 1'b0;
        repeat (blen - 1) @(negedge clk);
        mframes[0]++;
        total++; if (frame_cnt !== 16'(mframes[0])) begin
            bad++; $display("FAIL en_frame_done: got %0d want %0d", frame_cnt, mframes[0]);
        end
        hits = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #1; if (req0_ready || req1_ready) hits++;
        end
        total++; if ({hits == 0, sched_busy} !== 2'b10) begin
            bad++; $display("FAIL en_hold: got ready_cycles=%0d busy=%b want 0 and 0", hits, sched_busy);
        end
        enable = 1'b1; #1;
        total++; if (req0_ready !== 1'b1) begin
            bad++; $display("FAIL en_reenable: got %b want 1", req0_ready);
        end
        @(negedge clk); req0_valid = 1'b0;
        total++; if ({tx_en, tx_data} !== {1'b1, 8'h77}) begin
            bad++; $display("FAIL en_launch2: got %h want %h", {tx_en, tx_data}, {1'b1, 8'h77});
        end
        mframes[0]++;
        while (sched_busy && lim < 200) begin @(negedge clk); lim++; end
        total++; if ({sched_busy, frame_cnt} !== {1'b0, 16'(mframes[0])}) begin
            bad++; $display("FAIL en_final: got busy=%b cnt=%0d want 0 and %0d", sched_busy, frame_cnt, mframes[0]);
        end
    endtask

    task automatic test_reset_mid();
        for (int m = 0; m < 2; m++) begin
            auto_busy = 1'b1; blen = 20;
            @(negedge clk); req0_valid = 1'b1; req0_data = 8'h31;
            @(negedge clk); req0_valid = 1'b0;
            repeat (5) @(negedge clk);
            if (m == 0) begin
                arst_n = 1'b0; #1;
            end else begin
                rst = 1'b1; @(negedge clk);
            end
            total++; if ({tx_en, tx_data, last_src, frame_cnt, timeout_err, sched_busy} !== 28'd0) begin
                bad++; $display("FAIL midreset_%0d: got %h want 0", m, {tx_en, tx_data, last_src, frame_cnt, timeout_err, sched_busy});
            end
            @(negedge clk); arst_n = 1'b1; rst = 1'b0;
            mprio[0] = 1'b0; mprio[1] = 1'b0; mframes[0] = 0; mframes[1] = 0;
            @(negedge clk);
            req0_valid = 1'b1; req0_data = 8'h11; req1_valid = 1'b1; req1_data = 8'h22; #1;
            total++; if ({req0_ready, req1_ready} !== 2'b10) begin
                bad++; $display("FAIL midreset_grant_%0d: got %b want 10", m, {req0_ready, req1_ready});
            end
            do_rst();
        end
    endtask

    task automatic test_zero_gap();
        do_rst();
        auto_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            blen = $urandom_range(2, 6);
            run_sched(1'b1, $urandom_range(1, 4), $urandom_range(0, 4), 1'b0);
        end
        total++; if (z_timeout_err !== 1'b0) begin
            bad++; $display("FAIL zg_err: got %b want 0", z_timeout_err);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_timeout();
        test_enable();
        test_reset_mid();
        test_zero_gap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
